// File: rtl/mem_target_regfile.sv
// ----------------------------------------------------------------------------
// mem_target_regfile
//
// Purpose:
//   This is the responder end of the small memory bus (4-bit address, 8-bit
//   data). It holds a register file built from flops and returns read data
//   one cycle after the address is presented. It also keeps per-entry
//   "written" flags, saturating write and read counters, and a sticky error
//   flag that sets when a read hits an entry that has never been written.
//
// Bus protocol:
//   There is no valid/ready handshake. Every rising clk edge with rst low is
//   exactly one transaction. we=1 is a write and we=0 is a read. A read whose
//   result nobody uses still counts as a read.
//
// Ports:
//   clk        in   single clock; all state changes on the rising edge
//   rst        in   asynchronous, active-high reset
//   we         in   1 = write cycle, 0 = read cycle
//   addr       in   [ADDR_W-1:0] entry index for this cycle
//   wdata      in   [DATA_W-1:0] write data (used only when we=1)
//   rdata      out  [DATA_W-1:0] registered read data; held during writes
//   valid_map  out  [2**ADDR_W-1:0] bit i is set once entry i is written
//   uninit_err out  sticky flag for a read of a never-written entry
//   err_clr    in   clears uninit_err; a same-cycle new error wins
//   wr_count   out  [CNT_W-1:0] saturating count of write cycles
//   rd_count   out  [CNT_W-1:0] saturating count of read cycles
// ----------------------------------------------------------------------------
module mem_target_regfile #(
    parameter int                 ADDR_W   = 4,
    parameter int                 DATA_W   = 8,
    parameter logic [DATA_W-1:0]  INIT_VAL = 8'h00,
    parameter int                 CNT_W    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata,
    output logic [(1<<ADDR_W)-1:0]   valid_map,
    output logic                     uninit_err,
    input  logic                     err_clr,
    output logic [CNT_W-1:0]         wr_count,
    output logic [CNT_W-1:0]         rd_count
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q,  rdata_d;
    logic [DEPTH-1:0]  valid_q,  valid_d;
    logic              err_q,    err_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;

    logic              rd_uninit;

    // A read of an entry that was never written returns INIT_VAL, even if
    // the flop holds something else, and it raises the sticky error.
    assign rd_uninit = !we && !valid_q[addr];

    always_comb begin
        rdata_d  = rdata_q;
        valid_d  = valid_q;
        err_d    = err_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;

        if (we) begin
            valid_d[addr] = 1'b1;
            if (wr_cnt_q != {CNT_W{1'b1}}) begin
                wr_cnt_d = wr_cnt_q + CNT_W'(1);
            end
        end else begin
            rdata_d = valid_q[addr] ? mem_q[addr] : INIT_VAL;
            if (rd_cnt_q != {CNT_W{1'b1}}) begin
                rd_cnt_d = rd_cnt_q + CNT_W'(1);
            end
        end

        // A new error in the same cycle as a clear wins, so the order of
        // these two assignments matters.
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (rd_uninit) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= INIT_VAL;
            end
        end else if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q  <= INIT_VAL;
            valid_q  <= '0;
            err_q    <= 1'b0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            rdata_q  <= rdata_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    assign rdata      = rdata_q;
    assign valid_map  = valid_q;
    assign uninit_err = err_q;
    assign wr_count   = wr_cnt_q;
    assign rd_count   = rd_cnt_q;

endmodule

// File: tb/tb_mem_target_regfile.sv
// ----------------------------------------------------------------------------
// tb_mem_target_regfile
//
// Purpose:
//   This is the directed bench for mem_target_regfile. A table of one-cycle
//   vectors covers reads of unwritten entries, write-then-read, back-to-back
//   writes and the err_clr corner cases. Hand-written sequences then cover
//   counter saturation and an asynchronous reset asserted mid-cycle.
//
// Ports:
//   none (top-level bench)
// ----------------------------------------------------------------------------
module tb_mem_target_regfile;

    logic        clk;
    logic        rst;
    logic        we;
    logic [3:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic [15:0] valid_map;
    logic        uninit_err;
    logic        err_clr;
    logic [7:0]  wr_count;
    logic [7:0]  rd_count;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_target_regfile dut (
        .clk        (clk),
        .rst        (rst),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .valid_map  (valid_map),
        .uninit_err (uninit_err),
        .err_clr    (err_clr),
        .wr_count   (wr_count),
        .rd_count   (rd_count)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- vector table ----------------
    typedef struct {
        bit          do_rst;   // pulse reset before this vector
        logic        we;
        logic [3:0]  addr;
        logic [7:0]  wdata;
        logic        err_clr;
        logic [7:0]  exp_rdata;
        logic [15:0] exp_vmap;
        logic        exp_err;
        logic [7:0]  exp_wr;
        logic [7:0]  exp_rd;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    function automatic vec_t mk(bit r, logic w, logic [3:0] a, logic [7:0] d,
                                logic c, logic [7:0] er, logic [15:0] ev,
                                logic ee, logic [7:0] ew, logic [7:0] erd);
        vec_t v;
        v.do_rst = r;  v.we = w;  v.addr = a;  v.wdata = d;  v.err_clr = c;
        v.exp_rdata = er;  v.exp_vmap = ev;  v.exp_err = ee;
        v.exp_wr = ew;  v.exp_rd = erd;
        return v;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] er,
                             input logic [15:0] ev, input logic ee,
                             input logic [7:0] ew, input logic [7:0] erd);
        check({tag, ".rdata"},      {24'h0, rdata},      {24'h0, er});
        check({tag, ".valid_map"},  {16'h0, valid_map},  {16'h0, ev});
        check({tag, ".uninit_err"}, {31'h0, uninit_err}, {31'h0, ee});
        check({tag, ".wr_count"},   {24'h0, wr_count},   {24'h0, ew});
        check({tag, ".rd_count"},   {24'h0, rd_count},   {24'h0, erd});
    endtask

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic pulse_reset();
        rst = 1'b1;
        we = 1'b0; addr = '0; wdata = '0; err_clr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drive one transaction, let one rising edge pass, return at the
    // following negedge, where the outputs are stable.
    task automatic cycle(input logic w, input logic [3:0] a,
                         input logic [7:0] d, input logic c);
        we = w; addr = a; wdata = d; err_clr = c;
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; we = 1'b0; addr = '0; wdata = '0; err_clr = 1'b0;

        // Reset, then three reads of unwritten entries.
        vecs[0]  = mk(1, 0, 4'h0, 8'h00, 0, 8'h00, 16'h0000, 1, 8'd0, 8'd1);
        vecs[1]  = mk(0, 0, 4'h5, 8'h00, 0, 8'h00, 16'h0000, 1, 8'd0, 8'd2);
        vecs[2]  = mk(0, 0, 4'hF, 8'h00, 0, 8'h00, 16'h0000, 1, 8'd0, 8'd3);
        // Fresh reset, write 3 = A5, then read 3.
        vecs[3]  = mk(1, 1, 4'h3, 8'hA5, 0, 8'h00, 16'h0008, 0, 8'd1, 8'd0);
        vecs[4]  = mk(0, 0, 4'h3, 8'h00, 0, 8'hA5, 16'h0008, 0, 8'd1, 8'd1);
        // Fresh reset, 7 = 11 then 7 = 22, then read 7.
        vecs[5]  = mk(1, 1, 4'h7, 8'h11, 0, 8'h00, 16'h0080, 0, 8'd1, 8'd0);
        vecs[6]  = mk(0, 1, 4'h7, 8'h22, 0, 8'h00, 16'h0080, 0, 8'd2, 8'd0);
        vecs[7]  = mk(0, 0, 4'h7, 8'h00, 0, 8'h22, 16'h0080, 0, 8'd2, 8'd1);
        // rdata holds 22 across a write; then the err_clr corner cases.
        vecs[8]  = mk(0, 1, 4'h3, 8'h3C, 0, 8'h22, 16'h0088, 0, 8'd3, 8'd1);
        vecs[9]  = mk(0, 0, 4'h4, 8'h00, 0, 8'h00, 16'h0088, 1, 8'd3, 8'd2);
        vecs[10] = mk(0, 0, 4'h9, 8'h00, 1, 8'h00, 16'h0088, 1, 8'd3, 8'd3);
        vecs[11] = mk(0, 0, 4'h3, 8'h00, 1, 8'h3C, 16'h0088, 0, 8'd3, 8'd4);
        vecs[12] = mk(0, 0, 4'h3, 8'h00, 0, 8'h3C, 16'h0088, 0, 8'd3, 8'd5);
        vecs[13] = mk(0, 0, 4'h4, 8'h00, 0, 8'h00, 16'h0088, 1, 8'd3, 8'd6);
        vecs[14] = mk(0, 1, 4'h5, 8'h77, 1, 8'h00, 16'h00A8, 0, 8'd4, 8'd6);
        vecs[15] = mk(0, 0, 4'h5, 8'h00, 0, 8'h77, 16'h00A8, 0, 8'd4, 8'd7);
        // The read data is the value stored before the edge, not wdata.
        vecs[16] = mk(0, 1, 4'hC, 8'hE1, 0, 8'h77, 16'h10A8, 0, 8'd5, 8'd7);
        vecs[17] = mk(0, 0, 4'hC, 8'h99, 0, 8'hE1, 16'h10A8, 0, 8'd5, 8'd8);
        vecs[18] = mk(0, 0, 4'h7, 8'h00, 0, 8'h22, 16'h10A8, 0, 8'd5, 8'd9);

        // Reset state check.
        @(negedge clk);
        check_all("reset", 8'h00, 16'h0000, 1'b0, 8'd0, 8'd0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].do_rst) pulse_reset();
            cycle(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].err_clr);
            check_all($sformatf("vec%0d", i), vecs[i].exp_rdata,
                      vecs[i].exp_vmap, vecs[i].exp_err,
                      vecs[i].exp_wr, vecs[i].exp_rd);
        end

        // Saturation: 300 writes, addr = i mod 16, data = i mod 256.
        pulse_reset();
        for (int i = 0; i < 300; i++) begin
            cycle(1'b1, 4'(i), 8'(i), 1'b0);
            if (i == 253) check("sat.wr_254", {24'h0, wr_count}, 32'hFE);
            if (i == 254) check("sat.wr_255", {24'h0, wr_count}, 32'hFF);
        end
        check_all("sat", 8'h00, 16'hFFFF, 1'b0, 8'hFF, 8'd0);
        // The last write to addr 0 was i = 288, so the stored value is 8'h20.
        cycle(1'b0, 4'h0, 8'h00, 1'b0);
        check_all("sat_rd", 8'h20, 16'hFFFF, 1'b0, 8'hFF, 8'd1);

        // Asynchronous reset asserted mid-cycle, with no clock edge.
        pulse_reset();
        cycle(1'b0, 4'hF, 8'h00, 1'b0);
        cycle(1'b1, 4'h2, 8'h5A, 1'b0);
        cycle(1'b0, 4'h2, 8'h00, 1'b0);
        check_all("pre_arst", 8'h5A, 16'h0004, 1'b1, 8'd1, 8'd2);
        #2 rst = 1'b1;     // asserted between the negedge and the next posedge
        #1;
        check_all("arst", 8'h00, 16'h0000, 1'b0, 8'd0, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b0, 4'h2, 8'h00, 1'b0);
        check_all("post_arst", 8'h00, 16'h0000, 1'b1, 8'd0, 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
